// File: rtl/clause_data_if.sv
// clause_data_if: groups the capture strobes, snapshot inputs, read indices
// and decoded/aggregate outputs of clause_data. clk/rst are kept outside.
// Strobes carry no handshake: a strobe sampled high is always accepted.
interface clause_data_if #(
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) ();
    localparam int VI = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam int LI = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;

    logic                                   set_clause_i;
    logic [NUM_VARS*2-1:0]                  clause_i;
    logic                                   set_vs_i;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vs_i;
    logic                                   set_ls_i;
    logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   ls_i;
    logic [VI-1:0]                          var_idx_i;
    logic [LI-1:0]                          lvl_idx_i;

    logic [1:0]                             lit_o;
    logic [2:0]                             vs_value_o;
    logic [WIDTH_LVL-1:0]                   vs_lvl_o;
    logic [WIDTH_BIN_ID-1:0]                ls_dcd_bin_o;
    logic                                   ls_has_bkt_o;
    logic [VI:0]                            clause_len_o;
    logic                                   lit_err_o;
    logic [VI:0]                            assigned_cnt_o;
    logic [WIDTH_LVL-1:0]                   max_lvl_o;
    logic [LI:0]                            bkt_cnt_o;

    // Load controller / testbench side
    modport master (
        output set_clause_i, clause_i, set_vs_i, vs_i, set_ls_i, ls_i,
               var_idx_i, lvl_idx_i,
        input  lit_o, vs_value_o, vs_lvl_o, ls_dcd_bin_o, ls_has_bkt_o,
               clause_len_o, lit_err_o, assigned_cnt_o, max_lvl_o, bkt_cnt_o
    );

    // clause_data side
    modport slave (
        input  set_clause_i, clause_i, set_vs_i, vs_i, set_ls_i, ls_i,
               var_idx_i, lvl_idx_i,
        output lit_o, vs_value_o, vs_lvl_o, ls_dcd_bin_o, ls_has_bkt_o,
               clause_len_o, lit_err_o, assigned_cnt_o, max_lvl_o, bkt_cnt_o
    );
endinterface

// File: rtl/clause_data.sv
// clause_data: snapshot-and-decode observation block for one SAT-engine bin.
// Three independent snapshot registers (clause, var states, lvl states) are
// loaded by their strobes; per-index fields and aggregate statistics are
// decoded from the snapshots and registered, giving 2-cycle strobe-to-output
// and 1-cycle index-to-output latency.
// Optional macro CLAUSE_DATA_DISPLAY_EN adds simulation-only capture logging;
// the hardware behaviour is the same with or without it.
// WIDTH_VAR_STATES must equal 3+WIDTH_LVL, WIDTH_LVL_STATES must equal
// WIDTH_BIN_ID+1.
module clause_data #(
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) (
    input  logic           clk,
    input  logic           rst,
    clause_data_if.slave   bus
);
    localparam int VI = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
    localparam int LI = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;
    localparam logic [VI:0] ONE_V = 1;
    localparam logic [LI:0] ONE_L = 1;

    // Snapshot registers
    logic [NUM_VARS*2-1:0]                clause_q, clause_d;
    logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vs_q, vs_d;
    logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] ls_q, ls_d;

    // Registered outputs
    logic [1:0]              lit_q, lit_d;
    logic [2:0]              vs_value_q, vs_value_d;
    logic [WIDTH_LVL-1:0]    vs_lvl_q, vs_lvl_d;
    logic [WIDTH_BIN_ID-1:0] ls_dcd_bin_q, ls_dcd_bin_d;
    logic                    ls_has_bkt_q, ls_has_bkt_d;
    logic [VI:0]             clause_len_q, clause_len_d;
    logic                    lit_err_q, lit_err_d;
    logic [VI:0]             assigned_cnt_q, assigned_cnt_d;
    logic [WIDTH_LVL-1:0]    max_lvl_q, max_lvl_d;
    logic [LI:0]             bkt_cnt_q, bkt_cnt_d;

    // Snapshot next-state: load the full vector on its strobe, else hold
    always_comb begin
        clause_d = bus.set_clause_i ? bus.clause_i : clause_q;
        vs_d     = bus.set_vs_i     ? bus.vs_i     : vs_q;
        ls_d     = bus.set_ls_i     ? bus.ls_i     : ls_q;
    end

    // Per-index decode and aggregate statistics from the current snapshots;
    // an index with no matching entry leaves the per-index fields at zero
    always_comb begin
        lit_d          = '0;
        vs_value_d     = '0;
        vs_lvl_d       = '0;
        ls_dcd_bin_d   = '0;
        ls_has_bkt_d   = 1'b0;
        clause_len_d   = '0;
        lit_err_d      = 1'b0;
        assigned_cnt_d = '0;
        max_lvl_d      = '0;
        bkt_cnt_d      = '0;
        for (int i = 0; i < NUM_VARS; i++) begin
            // Literal codes: 00 absent, 10 pos, 01 neg, 11 illegal (still counted)
            if (clause_q[2*i +: 2] != 2'b00) begin
                clause_len_d = clause_len_d + ONE_V;
            end
            if (clause_q[2*i +: 2] == 2'b11) begin
                lit_err_d = 1'b1;
            end
            // Value bits [1:0] non-zero means assigned (conflict included)
            if (vs_q[i*WIDTH_VAR_STATES+WIDTH_LVL +: 2] != 2'b00) begin
                assigned_cnt_d = assigned_cnt_d + ONE_V;
                if (vs_q[i*WIDTH_VAR_STATES +: WIDTH_LVL] > max_lvl_d) begin
                    max_lvl_d = vs_q[i*WIDTH_VAR_STATES +: WIDTH_LVL];
                end
            end
            if (int'(bus.var_idx_i) == i) begin
                lit_d      = clause_q[2*i +: 2];
                vs_value_d = vs_q[i*WIDTH_VAR_STATES+WIDTH_LVL +: 3];
                vs_lvl_d   = vs_q[i*WIDTH_VAR_STATES +: WIDTH_LVL];
            end
        end
        for (int j = 0; j < NUM_LVLS; j++) begin
            if (ls_q[j*WIDTH_LVL_STATES]) begin
                bkt_cnt_d = bkt_cnt_d + ONE_L;
            end
            if (int'(bus.lvl_idx_i) == j) begin
                ls_dcd_bin_d = ls_q[j*WIDTH_LVL_STATES+1 +: WIDTH_BIN_ID];
                ls_has_bkt_d = ls_q[j*WIDTH_LVL_STATES];
            end
        end
    end

    // State registers; reset clears snapshots and outputs and beats strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            clause_q       <= '0;
            vs_q           <= '0;
            ls_q           <= '0;
            lit_q          <= '0;
            vs_value_q     <= '0;
            vs_lvl_q       <= '0;
            ls_dcd_bin_q   <= '0;
            ls_has_bkt_q   <= 1'b0;
            clause_len_q   <= '0;
            lit_err_q      <= 1'b0;
            assigned_cnt_q <= '0;
            max_lvl_q      <= '0;
            bkt_cnt_q      <= '0;
        end else begin
            clause_q       <= clause_d;
            vs_q           <= vs_d;
            ls_q           <= ls_d;
            lit_q          <= lit_d;
            vs_value_q     <= vs_value_d;
            vs_lvl_q       <= vs_lvl_d;
            ls_dcd_bin_q   <= ls_dcd_bin_d;
            ls_has_bkt_q   <= ls_has_bkt_d;
            clause_len_q   <= clause_len_d;
            lit_err_q      <= lit_err_d;
            assigned_cnt_q <= assigned_cnt_d;
            max_lvl_q      <= max_lvl_d;
            bkt_cnt_q      <= bkt_cnt_d;
        end
    end

    assign bus.lit_o          = lit_q;
    assign bus.vs_value_o     = vs_value_q;
    assign bus.vs_lvl_o       = vs_lvl_q;
    assign bus.ls_dcd_bin_o   = ls_dcd_bin_q;
    assign bus.ls_has_bkt_o   = ls_has_bkt_q;
    assign bus.clause_len_o   = clause_len_q;
    assign bus.lit_err_o      = lit_err_q;
    assign bus.assigned_cnt_o = assigned_cnt_q;
    assign bus.max_lvl_o      = max_lvl_q;
    assign bus.bkt_cnt_o      = bkt_cnt_q;

`ifdef CLAUSE_DATA_DISPLAY_EN
    // Simulation-only log of every accepted capture
    always @(posedge clk) begin
        if (!rst && bus.set_clause_i) begin
            $write("set_clause:");
            for (int i = 0; i < NUM_VARS; i++) begin
                case (bus.clause_i[2*i +: 2])
                    2'b10:   $write(" +%0d", i + 1);
                    2'b01:   $write(" -%0d", i + 1);
                    2'b11:   $write(" ?%0d", i + 1);
                    default: ;
                endcase
            end
            $write("\n");
        end
        if (!rst && bus.set_vs_i) begin
            for (int i = 0; i < NUM_VARS; i++) begin
                $display("set_vs: var %0d value %b implied %0d lvl %0d", i,
                         bus.vs_i[i*WIDTH_VAR_STATES+WIDTH_LVL +: 2],
                         bus.vs_i[i*WIDTH_VAR_STATES+WIDTH_LVL+2],
                         bus.vs_i[i*WIDTH_VAR_STATES +: WIDTH_LVL]);
            end
        end
        if (!rst && bus.set_ls_i) begin
            for (int j = 0; j < NUM_LVLS; j++) begin
                $display("set_ls: lvl %0d dcd_bin %0d has_bkt %0d", j,
                         bus.ls_i[j*WIDTH_LVL_STATES+1 +: WIDTH_BIN_ID],
                         bus.ls_i[j*WIDTH_LVL_STATES]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_clause_data.sv
// tb_clause_data: table-driven vectors plus hand sequences for latency,
// back-to-back strobes and reset; expected records queue in a scoreboard.
module tb_clause_data;
    logic clk;
    logic rst;

    clause_data_if bus ();

    clause_data dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  clause;
        logic [151:0] vs;
        logic [87:0]  ls;
        logic [2:0]   vidx;
        logic [2:0]   lidx;
    } stim_t;

    typedef struct packed {
        logic [1:0]  lit;
        logic [2:0]  val;
        logic [15:0] lvl;
        logic [9:0]  dcd;
        logic        bkt;
        logic [3:0]  len;
        logic        err;
        logic [3:0]  acnt;
        logic [15:0] maxl;
        logic [3:0]  bcnt;
    } exp_t;

    typedef struct {
        string name;
        stim_t s;
        exp_t  e;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [151:0] vs_put(logic [151:0] v, int i, logic [2:0] val, logic [15:0] lvl);
        v[i*19 +: 19] = {val, lvl};
        return v;
    endfunction

    function automatic logic [87:0] ls_put(logic [87:0] v, int j, logic [9:0] dcd, logic bkt);
        v[j*11 +: 11] = {dcd, bkt};
        return v;
    endfunction

    function automatic exp_t mk_exp(logic [1:0] lit, logic [2:0] val, logic [15:0] lvl,
                                    logic [9:0] dcd, logic bkt, logic [3:0] len, logic err,
                                    logic [3:0] acnt, logic [15:0] maxl, logic [3:0] bcnt);
        exp_t e;
        e.lit = lit; e.val = val; e.lvl = lvl; e.dcd = dcd; e.bkt = bkt;
        e.len = len; e.err = err; e.acnt = acnt; e.maxl = maxl; e.bcnt = bcnt;
        return e;
    endfunction

    // Reference model for random and swept vectors
    function automatic exp_t model(stim_t s);
        exp_t e;
        logic [18:0] ent;
        logic [10:0] lent;
        e = '0;
        for (int i = 0; i < 8; i++) begin
            case (s.clause[2*i +: 2])
                2'b00: ;
                2'b11: begin e.len++; e.err = 1'b1; end
                default: e.len++;
            endcase
            ent = s.vs[i*19 +: 19];
            if (ent[17:16] != 2'b00) begin
                e.acnt++;
                if (ent[15:0] > e.maxl) e.maxl = ent[15:0];
            end
        end
        for (int j = 0; j < 8; j++) begin
            lent = s.ls[j*11 +: 11];
            if (lent[0]) e.bcnt++;
        end
        e.lit = s.clause[int'(s.vidx)*2 +: 2];
        ent   = s.vs[int'(s.vidx)*19 +: 19];
        e.val = ent[18:16];
        e.lvl = ent[15:0];
        lent  = s.ls[int'(s.lidx)*11 +: 11];
        e.dcd = lent[10:1];
        e.bkt = lent[0];
        return e;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.clause = 16'($urandom_range(0, 65535));
        for (int k = 0; k < 8; k++) begin
            s.vs[k*19 +: 19] = {3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535))};
            s.ls[k*11 +: 11] = 11'($urandom_range(0, 2047));
        end
        s.vidx = 3'($urandom_range(0, 7));
        s.lidx = 3'($urandom_range(0, 7));
        return s;
    endfunction

    task automatic chk(string nm, logic [15:0] act, logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual %h expected %h", nm, act, want);
        end
    endtask

    // Pop the oldest expected record and compare against the DUT outputs
    task automatic compare_pop(string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty", nm);
            return;
        end
        e = exp_q.pop_front();
        chk({nm, ".lit"},  16'(bus.lit_o),          16'(e.lit));
        chk({nm, ".val"},  16'(bus.vs_value_o),     16'(e.val));
        chk({nm, ".lvl"},  bus.vs_lvl_o,            e.lvl);
        chk({nm, ".dcd"},  16'(bus.ls_dcd_bin_o),   16'(e.dcd));
        chk({nm, ".bkt"},  16'(bus.ls_has_bkt_o),   16'(e.bkt));
        chk({nm, ".len"},  16'(bus.clause_len_o),   16'(e.len));
        chk({nm, ".err"},  16'(bus.lit_err_o),      16'(e.err));
        chk({nm, ".acnt"}, 16'(bus.assigned_cnt_o), 16'(e.acnt));
        chk({nm, ".maxl"}, bus.max_lvl_o,           e.maxl);
        chk({nm, ".bcnt"}, 16'(bus.bkt_cnt_o),      16'(e.bcnt));
    endtask

    task automatic drive(stim_t s, logic stb);
        bus.clause_i     = s.clause;
        bus.vs_i         = s.vs;
        bus.ls_i         = s.ls;
        bus.var_idx_i    = s.vidx;
        bus.lvl_idx_i    = s.lidx;
        bus.set_clause_i = stb;
        bus.set_vs_i     = stb;
        bus.set_ls_i     = stb;
    endtask

    task automatic strobes_off();
        bus.set_clause_i = 1'b0;
        bus.set_vs_i     = 1'b0;
        bus.set_ls_i     = 1'b0;
    endtask

    // Load all three snapshots and check after the 2-cycle latency
    task automatic apply(string nm, stim_t s, exp_t e);
        @(negedge clk);
        drive(s, 1'b1);
        exp_q.push_back(e);
        @(negedge clk);
        strobes_off();
        @(posedge clk);
        #1;
        compare_pop(nm);
    endtask

    vec_t  vecs[4];
    stim_t base, sa, sb, sm;

    initial begin
        // Table of vectors
        base.clause = 16'h0009;
        base.vs     = '0;
        base.vs     = vs_put(base.vs, 0, 3'b110, 16'd5);
        base.vs     = vs_put(base.vs, 3, 3'b001, 16'd9);
        base.ls     = '0;
        base.ls     = ls_put(base.ls, 2, 10'h155, 1'b1);
        base.ls     = ls_put(base.ls, 7, 10'h3FF, 1'b1);
        base.vidx   = 3'd0;
        base.lidx   = 3'd2;
        vecs[0].name = "v0_plan";
        vecs[0].s    = base;
        vecs[0].e    = mk_exp(2'b01, 3'b110, 16'd5, 10'h155, 1'b1, 4'd2, 1'b0, 4'd2, 16'd9, 4'd2);

        vecs[1].name     = "v1_illegal";
        vecs[1].s        = base;
        vecs[1].s.clause = 16'hC000;
        vecs[1].s.vidx   = 3'd7;
        vecs[1].s.lidx   = 3'd7;
        vecs[1].e        = mk_exp(2'b11, 3'b000, 16'd0, 10'h3FF, 1'b1, 4'd1, 1'b1, 4'd2, 16'd9, 4'd2);

        vecs[2].name     = "v2_full";
        vecs[2].s.clause = 16'hFFFF;
        for (int k = 0; k < 8; k++) begin
            vecs[2].s.vs[k*19 +: 19] = {3'b011, 16'hFFFF};
            vecs[2].s.ls[k*11 +: 11] = {10'h3FF, 1'b1};
        end
        vecs[2].s.vidx = 3'd5;
        vecs[2].s.lidx = 3'd4;
        vecs[2].e      = mk_exp(2'b11, 3'b011, 16'hFFFF, 10'h3FF, 1'b1, 4'd8, 1'b1, 4'd8, 16'hFFFF, 4'd8);

        vecs[3].name     = "v3_unsigned";
        vecs[3].s.clause = 16'h0000;
        for (int k = 0; k < 8; k++) vecs[3].s.vs[k*19 +: 19] = {3'b100, 16'hFFFF};
        vecs[3].s.vs   = vs_put(vecs[3].s.vs, 2, 3'b001, 16'h8000);
        vecs[3].s.vs   = vs_put(vecs[3].s.vs, 5, 3'b010, 16'h7FFF);
        vecs[3].s.ls   = '0;
        vecs[3].s.vidx = 3'd2;
        vecs[3].s.lidx = 3'd0;
        vecs[3].e      = mk_exp(2'b00, 3'b001, 16'h8000, 10'h000, 1'b0, 4'd0, 1'b0, 4'd2, 16'h8000, 4'd0);

        // Reset with all strobes high and non-zero data
        rst = 1'b1;
        drive(vecs[2].s, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.push_back('0);
        compare_pop("reset");
        @(negedge clk);
        rst = 1'b0;
        strobes_off();
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        compare_pop("post_reset");

        // Table-driven vectors
        for (int v = 0; v < 4; v++) apply(vecs[v].name, vecs[v].s, vecs[v].e);

        // Index sweep over the plan data
        apply("sweep_load", base, vecs[0].e);
        for (int i = 0; i < 8; i++) begin
            sm      = base;
            sm.vidx = 3'(i);
            sm.lidx = 3'(7 - i);
            @(negedge clk);
            bus.var_idx_i = sm.vidx;
            bus.lvl_idx_i = sm.lidx;
            exp_q.push_back(model(sm));
            @(posedge clk);
            #1;
            compare_pop($sformatf("sweep%0d", i));
        end

        // Simultaneous strobes: old data after edge t, new after t+1
        apply("lat_base", base, vecs[0].e);
        sm      = vecs[2].s;
        sm.vidx = base.vidx;
        sm.lidx = base.lidx;
        @(negedge clk);
        drive(sm, 1'b1);
        exp_q.push_back(vecs[0].e);
        @(posedge clk);
        #1;
        compare_pop("lat_old");
        @(negedge clk);
        strobes_off();
        exp_q.push_back(model(sm));
        @(posedge clk);
        #1;
        compare_pop("lat_new");

        // Index change alone: 1 edge
        @(negedge clk);
        sm.vidx = 3'd3;
        sm.lidx = 3'd6;
        bus.var_idx_i = sm.vidx;
        bus.lvl_idx_i = sm.lidx;
        exp_q.push_back(model(sm));
        @(posedge clk);
        #1;
        compare_pop("idx_only");

        // Strobes held on consecutive cycles: last-sampled vector wins
        sa = vecs[3].s;
        sb = rand_stim();
        sb.vidx = sa.vidx;
        sb.lidx = sa.lidx;
        @(negedge clk);
        drive(sa, 1'b1);
        @(negedge clk);
        drive(sb, 1'b1);
        exp_q.push_back(model(sa));
        @(posedge clk);
        #1;
        compare_pop("burst_a");
        @(negedge clk);
        strobes_off();
        exp_q.push_back(model(sb));
        @(posedge clk);
        #1;
        compare_pop("burst_b");

        // Random vectors
        for (int r = 0; r < 6; r++) begin
            sm = rand_stim();
            apply($sformatf("rand%0d", r), sm, model(sm));
        end

        // Strobe together with reset: reset wins, everything cleared
        @(negedge clk);
        rst              = 1'b1;
        bus.set_clause_i = 1'b1;
        bus.clause_i     = 16'hFFFF;
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        compare_pop("rst_strobe");
        @(negedge clk);
        rst = 1'b0;
        strobes_off();
        @(posedge clk);
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        compare_pop("rst_cleared");

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover actual %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout actual running expected finished");
        $fatal(1, "timeout");
    end
endmodule
